hvac_zone_arbiter: RTL and testbench

- Shares one heating/cooling plant between N thermostat zones.
- Each zone raises heat_req or cool_req. The arbiter grants the plant to one zone at a time, round-robin.
- Enforces minimum run time, maximum run time when other zones are waiting, and an idle dwell between grants to protect the compressor.
- Output plant_mode uses the plant's existing {heating, cooling} encoding and drives the plant directly.

---
 rtl/hvac_pkg.sv | 23 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/hvac_zone_arbiter.sv | 144 ++++++++++++++
 tb/tb_hvac_zone_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// rtl/hvac_pkg.sv - shared constants, state type and width helper for the HVAC zone arbiter
// Purpose: plant mode encodings ({heating, cooling}), arbiter FSM states and
//          a clog2 helper that never returns zero.
// Ports:   none (package)
package hvac_pkg;

   localparam logic [1:0] MODE_IDLE = 2'b00;
   localparam logic [1:0] MODE_COOL = 2'b01;
   localparam logic [1:0] MODE_HEAT = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DWELL = 2'b10
   } state_t;

   // Width needed to index/count up to v-1; at least one bit so that a
   // bound of 1 or 2 still yields a legal vector.
   function automatic int clog2w(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
// Purpose: returns the first set bit of valid, searching upward from ptr+1
//          and wrapping from N-1 to 0; ptr itself is checked last.
// Ports:   valid [N] - candidate vector
//          ptr   [W] - index of the previous winner
//          found     - at least one candidate exists
//          idx   [W] - chosen index (0 when found=0)
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [W:0]   sum;
   logic [W-1:0] cand;

   // Walk the offsets from farthest to nearest so the nearest hit
   // overwrites the others and wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      sum   = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         sum = {1'b0, ptr} + (W+1)'(k);
         if (sum >= (W+1)'(N))
            sum = sum - (W+1)'(N);
         cand = sum[W-1:0];
         if (valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/hvac_zone_arbiter.sv
// rtl/hvac_zone_arbiter.sv - round-robin arbiter sharing one heat/cool plant among zones
// Purpose: grants the plant to one zone at a time with minimum run time,
//          maximum run time under contention and a forced idle dwell.
// Ports:   clk, rst_n            - clock, asynchronous active-low reset
//          heat_req, cool_req [N] - per-zone level requests
//          plant_mode [2]        - {heating, cooling}, drives the plant
//          grant_valid           - a zone owns the plant
//          grant_zone [ZW]       - owning zone, 0 when idle
//          req_conflict [N]      - registered heat&cool per zone
module hvac_zone_arbiter
   import hvac_pkg::*;
#(
   parameter int N_ZONES        = 4,
   parameter int MIN_RUN_CYCLES = 8,
   parameter int MAX_RUN_CYCLES = 32,
   parameter int DWELL_CYCLES   = 4,
   localparam int ZW = clog2w(N_ZONES),
   localparam int RW = clog2w(MAX_RUN_CYCLES + 1),
   localparam int DW = clog2w(DWELL_CYCLES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_ZONES-1:0] heat_req,
   input  logic [N_ZONES-1:0] cool_req,
   output logic [1:0]         plant_mode,
   output logic               grant_valid,
   output logic [ZW-1:0]      grant_zone,
   output logic [N_ZONES-1:0] req_conflict
);

   state_t       state, state_n;
   logic [ZW-1:0] rr_ptr, rr_ptr_n;
   logic [RW-1:0] run_cnt, run_cnt_n;
   logic [DW-1:0] dwell_cnt, dwell_cnt_n;
   logic [1:0]    mode_n;
   logic          grant_valid_n;
   logic [ZW-1:0] grant_zone_n;

   logic [N_ZONES-1:0] req_valid;
   logic [N_ZONES-1:0] owner_mask;
   logic               pick_found;
   logic [ZW-1:0]      pick_idx;
   logic               owner_ok;
   logic               others_waiting;
   logic               release_now;

   // A zone asking for both modes at once is not a usable request.
   assign req_valid = heat_req ^ cool_req;

   rr_pick #(
      .N (N_ZONES),
      .W (ZW)
   ) u_rr_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // The owner keeps its claim only while it still asks, cleanly, for the
   // mode it was granted; a flip counts as a drop so the plant never swaps
   // heat and cool without passing through idle and dwell.
   always_comb begin
      owner_mask             = '0;
      owner_mask[grant_zone] = 1'b1;
      owner_ok               = 1'b0;
      if (plant_mode == MODE_HEAT)
         owner_ok = heat_req[grant_zone] & ~cool_req[grant_zone];
      else if (plant_mode == MODE_COOL)
         owner_ok = cool_req[grant_zone] & ~heat_req[grant_zone];
      others_waiting = |(req_valid & ~owner_mask);
      release_now    = (run_cnt >= RW'(MIN_RUN_CYCLES - 1)) &&
                       (!owner_ok ||
                        ((run_cnt >= RW'(MAX_RUN_CYCLES - 1)) && others_waiting));
   end

   always_comb begin
      state_n       = state;
      rr_ptr_n      = rr_ptr;
      run_cnt_n     = run_cnt;
      dwell_cnt_n   = dwell_cnt;
      mode_n        = plant_mode;
      grant_valid_n = grant_valid;
      grant_zone_n  = grant_zone;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_n       = RUN;
               grant_valid_n = 1'b1;
               grant_zone_n  = pick_idx;
               mode_n        = heat_req[pick_idx] ? MODE_HEAT : MODE_COOL;
               rr_ptr_n      = pick_idx;
               run_cnt_n     = '0;
            end
         end
         RUN: begin
            if (release_now) begin
               state_n       = DWELL;
               mode_n        = MODE_IDLE;
               grant_valid_n = 1'b0;
               grant_zone_n  = '0;
               dwell_cnt_n   = '0;
            end else if (run_cnt < RW'(MAX_RUN_CYCLES)) begin
               run_cnt_n = run_cnt + RW'(1);
            end
         end
         DWELL: begin
            if (dwell_cnt >= DW'(DWELL_CYCLES - 1))
               state_n = IDLE;
            else
               dwell_cnt_n = dwell_cnt + DW'(1);
         end
         default: begin
            state_n       = IDLE;
            mode_n        = MODE_IDLE;
            grant_valid_n = 1'b0;
            grant_zone_n  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= ZW'(N_ZONES - 1);
         run_cnt      <= '0;
         dwell_cnt    <= '0;
         plant_mode   <= MODE_IDLE;
         grant_valid  <= 1'b0;
         grant_zone   <= '0;
         req_conflict <= '0;
      end else begin
         state        <= state_n;
         rr_ptr       <= rr_ptr_n;
         run_cnt      <= run_cnt_n;
         dwell_cnt    <= dwell_cnt_n;
         plant_mode   <= mode_n;
         grant_valid  <= grant_valid_n;
         grant_zone   <= grant_zone_n;
         req_conflict <= heat_req & cool_req;
      end
   end

endmodule

// File: tb/tb_hvac_zone_arbiter.sv
// tb/tb_hvac_zone_arbiter.sv - self-checking bench for hvac_zone_arbiter
module tb_hvac_zone_arbiter;

   localparam int N     = 4;
   localparam int MIN   = 8;
   localparam int MAX   = 32;
   localparam int DWELL = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] heat_req = '0;
   logic [N-1:0] cool_req = '0;
   logic [1:0]   plant_mode;
   logic         grant_valid;
   logic [1:0]   grant_zone;
   logic [N-1:0] req_conflict;

   int errors = 0;
   int checks = 0;

   hvac_zone_arbiter #(
      .N_ZONES        (N),
      .MIN_RUN_CYCLES (MIN),
      .MAX_RUN_CYCLES (MAX),
      .DWELL_CYCLES   (DWELL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .heat_req     (heat_req),
      .cool_req     (cool_req),
      .plant_mode   (plant_mode),
      .grant_valid  (grant_valid),
      .grant_zone   (grant_zone),
      .req_conflict (req_conflict)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the plant, for how many visible cycles, and
   // how many idle cycles have been seen since the last release.
   int           m_owner;
   logic [1:0]   m_mode;
   int           m_held;
   int           m_gap;
   int           m_last;
   logic [N-1:0] m_conf;
   int           m_grants[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_owner = -1;
      m_mode  = 2'b00;
      m_held  = 0;
      m_gap   = 1000;
      m_last  = N - 1;
      m_conf  = '0;
   endfunction

   function automatic void model_edge(input logic [N-1:0] h, input logic [N-1:0] c);
      logic [N-1:0] v;
      bit owner_ok;
      bit others;
      int w;
      v      = h ^ c;
      m_conf = h & c;
      if (m_owner >= 0) begin
         owner_ok = (m_mode == 2'b10) ? (h[m_owner] && !c[m_owner])
                                      : (c[m_owner] && !h[m_owner]);
         others = 0;
         for (int i = 0; i < N; i++)
            if (i != m_owner && v[i]) others = 1;
         if (m_held >= MIN && (!owner_ok || (m_held >= MAX && others))) begin
            m_owner = -1;
            m_mode  = 2'b00;
            m_gap   = 1;
         end else begin
            m_held++;
         end
      end else if (m_gap >= DWELL + 1 && v != '0) begin
         w = -1;
         for (int i = 1; i <= N && w < 0; i++)
            if (v[(m_last + i) % N]) w = (m_last + i) % N;
         m_owner = w;
         m_last  = w;
         m_mode  = h[w] ? 2'b10 : 2'b01;
         m_held  = 1;
         m_grants.push_back(w);
      end else begin
         m_gap++;
      end
   endfunction

   task automatic check_outputs();
      chk("plant_mode", {30'd0, plant_mode}, {30'd0, m_mode});
      chk("grant_valid", {31'd0, grant_valid}, {31'd0, (m_owner >= 0)});
      chk("grant_zone", {30'd0, grant_zone}, (m_owner >= 0) ? m_owner : 0);
      chk("req_conflict", {28'd0, req_conflict}, {28'd0, m_conf});
   endtask

   task automatic step(input logic [N-1:0] h, input logic [N-1:0] c);
      heat_req = h;
      cool_req = c;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge(h, c);
      #1;
      check_outputs();
   endtask

   task automatic run(input logic [N-1:0] h, input logic [N-1:0] c, input int n);
      for (int i = 0; i < n; i++) step(h, c);
   endtask

   // Reset lands between edges; outputs must clear without a clock.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_mode", {30'd0, plant_mode}, 32'd0);
      chk("rst_async_gv", {31'd0, grant_valid}, 32'd0);
      chk("rst_async_gz", {30'd0, grant_zone}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] h, c;
      int len;
      model_reset();
      rst_n = 1'b0;
      #1;
      check_outputs();
      #16;
      rst_n = 1'b1;

      // Single heat request on zone 0.
      run(4'b0000, 4'b0000, 1);
      run(4'b0001, 4'b0000, 12);
      run(4'b0000, 4'b0000, 10);

      // Short cool pulse on zone 2 is stretched to the minimum run.
      run(4'b0000, 4'b0100, 3);
      run(4'b0000, 4'b0000, 20);

      // Full contention: fixed rotation, each grant lasts the maximum.
      async_reset();
      m_grants.delete();
      run(4'b1111, 4'b0000, 5 * MAX + 4 * (DWELL + 1) + 2);
      chk("rr_count", m_grants.size(), 5);
      if (m_grants.size() >= 5)
         for (int i = 0; i < 5; i++) chk("rr_order", m_grants[i], i % N);
      run(4'b0000, 4'b0000, 10);

      // Conflicting zone 1 is skipped; zone 3 cool wins.
      run(4'b0010, 4'b1010, 15);
      run(4'b0000, 4'b0000, 10);

      // Owner flips heat->cool mid-run; must pass through idle.
      async_reset();
      run(4'b0001, 4'b0000, 11);
      run(4'b0000, 4'b0001, 25);
      run(4'b0000, 4'b0000, 10);

      // Reset mid-run, then zone 0 is served first.
      run(4'b0100, 4'b0000, 6);
      async_reset();
      run(4'b1111, 4'b0000, 3);
      run(4'b0000, 4'b0000, 10);

      // Randomized traffic.
      for (int blk = 0; blk < 150; blk++) begin
         c = N'($urandom);
         h = N'($urandom);
         if ($urandom_range(0, 3) != 0) h = h & ~c;
         len = $urandom_range(1, 40);
         run(h, c, len);
         if ($urandom_range(0, 40) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
